// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the registered sequential ALU.
//   - OP_* : 3-bit operation codes driven on seq_alu.select
//   - state_e : handshake/sequencing FSM states
package seq_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: serial shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           load operands and begin (ignored while busy)
//   a, b            multiplicand / multiplier, WIDTH bits
//   busy            a multiply is in progress
//   done            this cycle's edge consumes the final multiplier bit
//   product         low WIDTH bits of a*b, valid while done=1
module seq_alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q,   a_d;
    logic [WIDTH-1:0] b_q,   b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_step;

    always_comb begin
        acc_step = acc_q + (b_q[0] ? a_q : '0);
        done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start && !busy_q) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = acc_step;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // The final step's sum is the product; the caller registers it on 'done'.
    assign product = acc_step;
    assign busy    = busy_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on both sides.
// Optional feature macro: SEQ_ALU_MUL_EN (serial multiply for select=011;
// when undefined, 011 completes in one cycle with err=1, zero=1).
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (accept = in_valid & in_ready)
//   i1, i2, select, c_in  operands, op code, carry-in (ADD only)
//   out_valid / out_ready result handshake
//   out, c_o, ov, zero    registered result and flags
//   err                   unsupported op issued
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [2:0]       select,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_o,
    output logic             ov,
    output logic             zero,
    output logic             err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             c_q, c_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] b_op;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_ov, alu_err;

`ifdef SEQ_ALU_MUL_EN
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (i1),
        .b       (i2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Combinational datapath: SUB reuses the adder as i1 + ~i2 + 1.
    always_comb begin
        b_op    = (select == OP_SUB) ? ~i2 : i2;
        cin     = (select == OP_SUB) ? 1'b1 : ((select == OP_ADD) ? c_in : 1'b0);
        sum     = {1'b0, i1} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_ov  = 1'b0;
        alu_err = 1'b0;
        case (select)
            OP_AND: alu_res = i1 & i2;
            OP_OR:  alu_res = i1 | i2;
            OP_XOR: alu_res = i1 ^ i2;
            OP_NOR: alu_res = ~(i1 | i2);
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_ov  = (i1[WIDTH-1] == b_op[WIDTH-1]) &&
                          (sum[WIDTH-1] != i1[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(i1) < $signed(i2))};
            OP_MUL: begin
                alu_res = '0;
`ifdef SEQ_ALU_MUL_EN
                alu_err = 1'b0;
`else
                alu_err = 1'b1;
`endif
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        c_d     = c_q;
        ov_d    = ov_q;
        zero_d  = zero_q;
        err_d   = err_q;
`ifdef SEQ_ALU_MUL_EN
        mul_start = (state_q == IDLE) && in_valid && (select == OP_MUL);
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    if (select == OP_MUL) begin
                        state_d = BUSY;
                    end else begin
                        out_d   = alu_res;
                        c_d     = alu_c;
                        ov_d    = alu_ov;
                        zero_d  = (alu_res == '0);
                        err_d   = alu_err;
                        state_d = DONE;
                    end
`else
                    out_d   = alu_res;
                    c_d     = alu_c;
                    ov_d    = alu_ov;
                    zero_d  = (alu_res == '0);
                    err_d   = alu_err;
                    state_d = DONE;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            BUSY: begin
                if (mul_done) begin
                    out_d   = mul_product;
                    c_d     = 1'b0;
                    ov_d    = 1'b0;
                    zero_d  = (mul_product == '0);
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; never wedge in BUSY.
                    state_d = IDLE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            c_q     <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            c_q     <= c_d;
            ov_q    <= ov_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign c_o       = c_q;
    assign ov        = ov_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule
